// File: rtl/i2c_byte_master.sv
// Byte-stream I2C write master: frames BYTES_PER_FRAME bytes between START and STOP.
// Optional macro I2C_NACK_ABORT_EN: a NACK ends the frame with STOP after that ACK phase.
module i2c_byte_master #(
    parameter int CLK_FREQ        = 125_000_000,
    parameter int I2C_FREQ        = 400_000,
    parameter int DATA_WIDTH      = 8,
    parameter int BYTES_PER_FRAME = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ack_o,
    output logic                  scl_o,
    output logic                  sda_o,
    output logic                  sda_oe_o,
    input  logic                  sda_i,
    output logic                  busy_o,
    output logic                  nack_o
);

    localparam int QTR = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QCW = (QTR > 1) ? $clog2(QTR) : 1;
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int FCW = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;

    localparam logic [QCW-1:0]        QTR_ZERO  = QCW'(0);
    localparam logic [QCW-1:0]        QTR_ONE   = QCW'(1);
    localparam logic [QCW-1:0]        QTR_LAST  = QCW'(QTR - 1);
    localparam logic [BCW-1:0]        BIT_ZERO  = BCW'(0);
    localparam logic [BCW-1:0]        BIT_ONE   = BCW'(1);
    localparam logic [BCW-1:0]        BIT_MSB   = BCW'(DATA_WIDTH - 1);
    localparam logic [FCW-1:0]        BYTE_ZERO = FCW'(0);
    localparam logic [FCW-1:0]        BYTE_ONE  = FCW'(1);
    localparam logic [FCW-1:0]        BYTE_LAST = FCW'(BYTES_PER_FRAME - 1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_ACK   = 3'd3,
        S_WAIT  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [QCW-1:0]        qtr_cnt_q, qtr_cnt_d;
    logic [1:0]            phase_q, phase_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  nack_q, nack_d;
    logic                  scl_q, scl_d;
    logic                  sda_q, sda_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  busy_q, busy_d;
    logic                  ack_s;
    logic                  qtr_end_s;
    logic                  phase_end_s;
    logic                  abort_s;

    assign qtr_end_s   = (qtr_cnt_q == QTR_LAST);
    assign phase_end_s = qtr_end_s && (phase_q == 2'd3);

`ifdef I2C_NACK_ABORT_EN
    assign abort_s = nack_q;
`else
    assign abort_s = 1'b0;
`endif

    // Next-state, counters, shift register and the upstream handshake
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        nack_d     = nack_q;
        ack_s      = 1'b0;

        if (state_q == S_IDLE) begin
            qtr_cnt_d = QTR_ZERO;
            phase_d   = 2'd0;
        end else if (qtr_end_s) begin
            qtr_cnt_d = QTR_ZERO;
            phase_d   = phase_q + 2'd1;
        end else begin
            qtr_cnt_d = qtr_cnt_q + QTR_ONE;
            phase_d   = phase_q;
        end

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    shift_d    = data_i;
                    ack_s      = 1'b1;
                    byte_cnt_d = BYTE_ZERO;
                    nack_d     = 1'b0;
                    state_d    = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (phase_end_s) begin
                    bit_cnt_d = BIT_MSB;
                    state_d   = S_BIT;
                end else begin
                    state_d = S_START;
                end
            end
            S_BIT: begin
                if (phase_end_s) begin
                    shift_d = shift_q << 1;
                    if (bit_cnt_q == BIT_ZERO) begin
                        state_d = S_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_ONE;
                        state_d   = S_BIT;
                    end
                end else begin
                    state_d = S_BIT;
                end
            end
            S_ACK: begin
                // Sample in the middle of the SCL-high window
                if ((phase_q == 2'd2) && (qtr_cnt_q == QTR_ZERO)) begin
                    nack_d = nack_q | sda_i;
                end else begin
                    nack_d = nack_q;
                end
                if (phase_end_s) begin
                    if ((byte_cnt_q == BYTE_LAST) || abort_s) begin
                        state_d = S_STOP;
                    end else if (valid_i) begin
                        shift_d    = data_i;
                        ack_s      = 1'b1;
                        byte_cnt_d = byte_cnt_q + BYTE_ONE;
                        bit_cnt_d  = BIT_MSB;
                        state_d    = S_BIT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_ACK;
                end
            end
            S_WAIT: begin
                if (valid_i) begin
                    shift_d    = data_i;
                    ack_s      = 1'b1;
                    byte_cnt_d = byte_cnt_q + BYTE_ONE;
                    bit_cnt_d  = BIT_MSB;
                    qtr_cnt_d  = QTR_ZERO;
                    phase_d    = 2'd0;
                    state_d    = S_BIT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_STOP: begin
                if (phase_end_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d   = S_IDLE;
                qtr_cnt_d = QTR_ZERO;
                phase_d   = 2'd0;
            end
        endcase
    end

    // Bus levels decoded from the upcoming state/quarter so the pins stay registered and aligned
    always_comb begin
        scl_d    = 1'b1;
        sda_d    = 1'b1;
        sda_oe_d = 1'b0;
        busy_d   = (state_d != S_IDLE);
        case (state_d)
            S_IDLE: begin
                scl_d    = 1'b1;
                sda_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
            S_START: begin
                scl_d    = (phase_d < 2'd2);
                sda_d    = 1'b0;
                sda_oe_d = 1'b1;
            end
            S_BIT: begin
                scl_d    = (phase_d == 2'd1) || (phase_d == 2'd2);
                sda_d    = shift_d[DATA_WIDTH-1];
                sda_oe_d = 1'b1;
            end
            S_ACK: begin
                scl_d    = (phase_d == 2'd1) || (phase_d == 2'd2);
                sda_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
            S_WAIT: begin
                scl_d    = 1'b0;
                sda_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
            S_STOP: begin
                scl_d    = (phase_d != 2'd0);
                sda_d    = (phase_d >= 2'd2);
                sda_oe_d = (phase_d < 2'd2);
            end
            default: begin
                scl_d    = 1'b1;
                sda_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            qtr_cnt_q  <= QTR_ZERO;
            phase_q    <= 2'd0;
            bit_cnt_q  <= BIT_ZERO;
            byte_cnt_q <= BYTE_ZERO;
            shift_q    <= DATA_ZERO;
            nack_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            qtr_cnt_q  <= qtr_cnt_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            nack_q     <= nack_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
        end
    end

    // ack_o must coincide with the capture edge, so it is the only combinational output
    assign ack_o    = ack_s & ~rst_i;
    assign scl_o    = scl_q;
    assign sda_o    = sda_q;
    assign sda_oe_o = sda_oe_q;
    assign busy_o   = busy_q;
    assign nack_o   = nack_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master: open-drain bus model with a simple ACK/NACK slave.
// Expectations follow I2C_NACK_ABORT_EN when it is defined for the build.
module tb_i2c_byte_master;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       sda_i;
    logic       ack_o, scl_o, sda_o, sda_oe_o, busy_o, nack_o;
    logic       bus_s;

    int tests_run    = 0;
    int tests_failed = 0;

    i2c_byte_master #(
        .CLK_FREQ       (4_000_000),
        .I2C_FREQ       (100_000),
        .DATA_WIDTH     (8),
        .BYTES_PER_FRAME(4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ack_o   (ack_o),
        .scl_o   (scl_o),
        .sda_o   (sda_o),
        .sda_oe_o(sda_oe_o),
        .sda_i   (sda_i),
        .busy_o  (busy_o),
        .nack_o  (nack_o)
    );

    always #5 clk = ~clk;

    // Open-drain line: master and slave can only pull low
    logic slave_sda = 1'b1;
    assign bus_s = (sda_oe_o ? sda_o : 1'b1) & slave_sda;
    assign sda_i = bus_s;

    // Bus monitor and slave
    logic       scl_prev = 1'b1;
    logic       bus_prev = 1'b1;
    int         rise_cnt = 0, fall_cnt = 0, start_cnt = 0, stop_cnt = 0;
    int         nack_frame = -1, nack_byte = -1;
    logic [7:0] cur_byte = 8'h00;
    logic [7:0] got_bytes[$];
    logic       ack_bits[$];

    always @(negedge clk) begin
        scl_prev <= scl_o;
        bus_prev <= bus_s;
        if (scl_prev === 1'b1 && scl_o === 1'b1 && bus_prev === 1'b1 && bus_s === 1'b0) begin
            start_cnt <= start_cnt + 1;
            rise_cnt  <= 0;
            fall_cnt  <= 0;
        end else if (scl_prev === 1'b1 && scl_o === 1'b1 && bus_prev === 1'b0 && bus_s === 1'b1) begin
            stop_cnt <= stop_cnt + 1;
        end else if (scl_prev === 1'b0 && scl_o === 1'b1) begin
            rise_cnt <= rise_cnt + 1;
            if (rise_cnt % 9 == 8) begin
                ack_bits.push_back(bus_s);
            end else begin
                cur_byte <= {cur_byte[6:0], bus_s};
                if (rise_cnt % 9 == 7) got_bytes.push_back({cur_byte[6:0], bus_s});
            end
        end else if (scl_prev === 1'b1 && scl_o === 1'b0) begin
            fall_cnt <= fall_cnt + 1;
            if (fall_cnt >= 1 && (fall_cnt - 1) % 9 == 7)
                slave_sda <= (start_cnt == nack_frame) && ((fall_cnt - 1) / 9 == nack_byte);
            else if (fall_cnt >= 1 && (fall_cnt - 1) % 9 == 8)
                slave_sda <= 1'b1;
        end
    end

    // Upstream byte source
    logic [7:0] up_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pop_dummy;
    logic       hold_v = 1'b1;
    int         ack_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(output logic got_ack);
        @(negedge clk);
        valid_i = (up_q.size() != 0) && !hold_v;
        data_i  = (up_q.size() != 0) ? up_q[0] : 8'h00;
        #1;
        got_ack = ack_o;
        if (ack_o === 1'b1) begin
            ack_total++;
            if (up_q.size() != 0) pop_dummy = up_q.pop_front();
        end
    endtask

    task automatic wait_frame(input int n_stops, input int budget, output int idle_gap, output logic nack_mid);
        int   base;
        int   cyc;
        logic ga;
        base = stop_cnt; cyc = 0; idle_gap = 0; nack_mid = 1'b0; hold_v = 1'b0;
        while ((stop_cnt < base + n_stops) && (cyc < budget)) begin
            step(ga); cyc++;
            if ((busy_o === 1'b0) && (stop_cnt > base) && (stop_cnt < base + n_stops)) begin
                idle_gap++;
                nack_mid = nack_o;
            end
        end
        hold_v = 1'b1;
        while ((busy_o !== 1'b0) && (cyc < budget)) begin
            step(ga); cyc++;
        end
        up_q.delete();
        chk("frame_done_in_budget", 32'(cyc < budget), 32'd1);
    endtask

    task automatic chk_bytes(input string tag, input int base);
        logic [31:0] g;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (base + i < got_bytes.size()) ? {24'h0, got_bytes[base + i]} : 32'hFFFF_FFFF;
            chk(tag, g, {24'h0, exp_q[i]});
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ga, nm;
        int   n, gap, acks, exp_n;
        int   b_base, k_base, a_base, s_base;

        // Reset with upstream already offering a byte
        rst_i = 1'b1; valid_i = 1'b1; data_i = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_scl", scl_o, 1'b1);
        chk("rst_oe", sda_oe_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0; valid_i = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy_o, 1'b0);
        chk("idle_sda", sda_o, 1'b1);
        chk("idle_nack", nack_o, 1'b0);

        // Basic frame, slave ACKs everything
        exp_q = '{8'hE8, 8'h00, 8'h0B, 8'h74};
        up_q = exp_q;
        b_base = got_bytes.size(); k_base = ack_bits.size(); a_base = ack_total; s_base = start_cnt;
        wait_frame(1, 5000, gap, nm);
        chk_bytes("t1_byte", b_base);
        chk("t1_nbytes", got_bytes.size() - b_base, 4);
        for (int i = 0; i < 4; i++)
            chk("t1_slave_ack", (k_base + i < ack_bits.size()) ? ack_bits[k_base + i] : 1'bx, 1'b0);
        chk("t1_ack_pulses", ack_total - a_base, 4);
        chk("t1_starts", start_cnt - s_base, 1);
        chk("t1_busy", busy_o, 1'b0);
        chk("t1_nack", nack_o, 1'b0);
        chk("t1_scl_idle", scl_o, 1'b1);

        // Upstream stalls after the second byte
        exp_q = '{8'h5A, 8'hC3, 8'h81, 8'h7E};
        up_q = exp_q;
        b_base = got_bytes.size(); a_base = ack_total;
        hold_v = 1'b0; n = 0; acks = 0;
        while (acks < 2 && n < 3000) begin step(ga); n++; if (ga === 1'b1) acks++; end
        chk("t2_first_acks", acks, 2);
        hold_v = 1'b1; acks = 0;
        for (int i = 0; i < 450; i++) begin step(ga); if (ga === 1'b1) acks++; end
        chk("t2_wait_scl", scl_o, 1'b0);
        chk("t2_wait_oe", sda_oe_o, 1'b0);
        chk("t2_wait_busy", busy_o, 1'b1);
        for (int i = 0; i < 50; i++) begin step(ga); if (ga === 1'b1) acks++; end
        chk("t2_no_ack_in_pause", acks, 0);
        hold_v = 1'b0;
        step(ga);
        chk("t2_resume_ack", ga, 1'b1);
        step(ga); n = 1;
        chk("t2_resume_oe", sda_oe_o, 1'b1);
        chk("t2_resume_msb", sda_o, 1'b1);
        chk("t2_resume_scl_low", scl_o, 1'b0);
        while (scl_o !== 1'b1 && n < 100) begin step(ga); n++; end
        chk("t2_resume_scl_rise", n, 11);
        wait_frame(1, 5000, gap, nm);
        chk_bytes("t2_byte", b_base);
        chk("t2_ack_pulses", ack_total - a_base, 4);

        // Slave NACKs the address byte
        nack_frame = start_cnt + 1; nack_byte = 0;
        exp_q = '{8'hE8, 8'h00, 8'h0B, 8'h74};
        up_q = exp_q;
        b_base = got_bytes.size(); k_base = ack_bits.size(); a_base = ack_total;
        wait_frame(1, 5000, gap, nm);
`ifdef I2C_NACK_ABORT_EN
        exp_n = 1;
`else
        exp_n = 4;
`endif
        chk("t3_ack_pulses", ack_total - a_base, exp_n);
        chk("t3_nbytes", got_bytes.size() - b_base, exp_n);
        chk("t3_addr_byte", (b_base < got_bytes.size()) ? got_bytes[b_base] : 8'hxx, 8'hE8);
        chk("t3_bus_nack", (k_base < ack_bits.size()) ? ack_bits[k_base] : 1'bx, 1'b1);
        chk("t3_nack_flag", nack_o, 1'b1);
        chk("t3_busy", busy_o, 1'b0);
        nack_frame = -1; nack_byte = -1;

        // Reset mid-frame, then a clean frame
        up_q = '{8'h3C, 8'h96, 8'h55, 8'hAA};
        s_base = start_cnt; hold_v = 1'b0; n = 0;
        while (!(start_cnt > s_base && rise_cnt >= 13) && n < 3000) begin step(ga); n++; end
        chk("t4_reached_bit", 32'(n < 3000), 32'd1);
        @(negedge clk);
        rst_i = 1'b1; valid_i = 1'b1;
        @(posedge clk); #1;
        chk("t4_rst_scl", scl_o, 1'b1);
        chk("t4_rst_oe", sda_oe_o, 1'b0);
        chk("t4_rst_busy", busy_o, 1'b0);
        chk("t4_rst_ack", ack_o, 1'b0);
        chk("t4_rst_nack", nack_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0; valid_i = 1'b0; hold_v = 1'b1; up_q.delete();
        repeat (3) step(ga);
        chk("t4_idle_after", busy_o, 1'b0);
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        up_q = exp_q;
        b_base = got_bytes.size(); a_base = ack_total;
        wait_frame(1, 5000, gap, nm);
        chk_bytes("t4_byte", b_base);
        chk("t4_ack_pulses", ack_total - a_base, 4);

        // Back-to-back frames, NACK on the last byte of the first
        nack_frame = start_cnt + 1; nack_byte = 3;
        exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
        up_q = exp_q;
        b_base = got_bytes.size(); a_base = ack_total; s_base = start_cnt;
        wait_frame(2, 8000, gap, nm);
        chk_bytes("t5_byte", b_base);
        chk("t5_ack_pulses", ack_total - a_base, 8);
        chk("t5_starts", start_cnt - s_base, 2);
        chk("t5_idle_gap", 32'(gap >= 1), 32'd1);
        chk("t5_nack_between", nm, 1'b1);
        chk("t5_nack_cleared", nack_o, 1'b0);
        chk("t5_busy", busy_o, 1'b0);
        nack_frame = -1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/i2c_byte_master.md
I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter I2C_FREQ, default 400_000, SCL frequency in Hz.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, byte width.
REQ-004 SHALL have parameter BYTES_PER_FRAME, default 4, bytes per START..STOP frame: slave address, register high, register low, data.
REQ-005 SHALL have port clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port data_i, input, DATA_WIDTH, byte from the upstream serializer, MSB first on the bus.
REQ-008 SHALL have port valid_i, input, 1, data_i holds a byte; tie high when upstream always presents data.
REQ-009 SHALL have port ack_o, output, 1, one-cycle pulse: data_i captured, upstream advances.
REQ-010 SHALL have port scl_o, output, 1, SCL level.
REQ-011 SHALL have port sda_o, output, 1, SDA drive value.
REQ-012 SHALL have port sda_oe_o, output, 1, SDA output enable; 0 releases the line.
REQ-013 SHALL have port sda_i, input, 1, sampled SDA.
REQ-014 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-015 SHALL have port nack_o, output, 1, sticky NACK flag.

Function
REQ-016 SHALL derive QTR = CLK_FREQ/(4*I2C_FREQ) (integer division, 78 at defaults); quarter counter runs 0..QTR-1 outside IDLE, is held at 0 in IDLE, and each bus phase spans quarters q0..q3.
REQ-017 SHALL implement states IDLE, START, BIT, ACK, WAIT, STOP.
REQ-018 SHALL, in IDLE with valid_i=1, load data_i into the shift register, pulse ack_o that same cycle, clear byte_cnt, clear nack_o, and enter START.
REQ-019 SHALL, in START, drive SDA low at q0 with SCL high, drive SCL low at q2, and enter BIT with bit_cnt=DATA_WIDTH-1 after q3.
REQ-020 SHALL, in BIT, per bit: drive SDA=shift MSB at q0 (SCL low), raise SCL at q1, lower SCL at q3, then shift left; after bit 0, enter ACK.
REQ-021 SHALL, in ACK, release SDA at q0, raise SCL at q1, sample sda_i at q2 (1 = NACK, sets nack_o), and lower SCL at q3.
REQ-022 SHALL, at end of ACK: if byte_cnt==BYTES_PER_FRAME-1, enter STOP; else if valid_i=1, load next byte, pulse ack_o, increment byte_cnt, enter BIT; else enter WAIT.
REQ-023 SHALL, in WAIT, hold SCL low and SDA released; on valid_i=1, load, pulse ack_o, increment byte_cnt, enter BIT at q0.
REQ-024 SHALL, in STOP, drive SDA low at q0, raise SCL at q1, release SDA at q2, and enter IDLE after q3; IDLE lasts at least one cycle before the next START.
REQ-025 SHALL hold ack_o to at most one cycle per byte, never asserted while the shift register is occupied.
REQ-026 SHALL change SDA only while SCL is low, except the START and STOP edges.

Reset
REQ-027 SHALL, on rst_i=1 at a clock edge, including mid-frame, force state=IDLE, scl_o=1, sda_o=1, sda_oe_o=0, ack_o=0, busy_o=0, nack_o=0, and clear all counters; no STOP is generated.

Configuration
REQ-028 SHALL, with I2C_NACK_ABORT_EN defined, treat a NACK as terminating the frame: after that ACK phase enter STOP, accept no remaining bytes of the frame.
REQ-029 SHALL, without I2C_NACK_ABORT_EN, record the NACK in nack_o only and complete all BYTES_PER_FRAME bytes.

Verification
REQ-030 SHALL cover: CLK_FREQ=4_000_000, I2C_FREQ=100_000 (QTR=10), bytes E8,00,0B,74, slave ACKs -> SDA at SCL rise gives 11101000,00000000,00001011,01110100, 4 ack_o pulses, STOP, busy_o=0, nack_o=0.
REQ-031 SHALL cover: valid_i low for 500 cycles after the 2nd byte -> SCL held low, SDA released, no ack_o; transfer resumes at q0 of BIT after valid_i rises.
REQ-032 SHALL cover: sda_i=1 at the address ACK -> with macro, STOP follows, nack_o=1, only 1 ack_o; without macro, 4 ack_o, 4 bytes sent, nack_o=1.
REQ-033 SHALL cover: rst_i pulsed at bit 3 of byte 2 -> next edge scl_o=1, sda_oe_o=0, busy_o=0; the next frame starts cleanly with byte 1.
REQ-034 SHALL cover: valid_i held high across 2 frames -> 8 ack_o pulses, each STOP followed by at least one IDLE cycle before START, nack_o cleared at the 2nd frame start.
